// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcode, field and state definitions for the compute-unit feeder
package cu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int TGT_MSB  = 11;
  localparam int TGT_LSB  = 8;
  localparam int SRC0_MSB = 7;
  localparam int SRC0_LSB = 4;
  localparam int SRC1_MSB = 3;
  localparam int SRC1_LSB = 0;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - program buffer, one write port and one asynchronous read port
module instr_buffer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  // Contents are deliberately left out of reset so a program survives it.
  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - assembles byte-stream instructions and replays them over valid/ready
module instr_fetch_sequencer
  import cu_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         wr_byte,
  input  logic               wr_valid,
  input  logic               clear,
  input  logic               start,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    prog_len,
  output logic               overflow
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]      prog_len_q, prog_len_d;
  logic                 half_q, half_d;
  logic [7:0]           hi_q, hi_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 overflow_q, overflow_d;

  logic                 mem_we;
  logic [ADDR_W-1:0]    rd_addr;
  logic [INSTR_W-1:0]   rd_data;
  logic                 full;
  logic                 last;

  assign full = (prog_len_q == (ADDR_W+1)'(DEPTH));
  assign last = ({1'b0, pc_q} == (prog_len_q - (ADDR_W+1)'(1)));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    half_d     = half_q;
    hi_d       = hi_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    rd_addr    = pc_q + ADDR_W'(1);

    case (state_q)
      ST_LOAD: begin
        // Read port looks at entry 0 so start can present it with one cycle of latency.
        rd_addr = '0;
        if (clear) begin
          wr_ptr_d   = '0;
          prog_len_d = '0;
          half_d     = 1'b0;
          overflow_d = 1'b0;
        end else if (start) begin
          half_d = 1'b0;
          pc_d   = '0;
          if (prog_len_q == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
            valid_d = 1'b1;
            instr_d = rd_data;
          end
        end else if (wr_valid) begin
          if (full) begin
            overflow_d = 1'b1;
          end else if (!half_q) begin
            hi_d   = wr_byte;
            half_d = 1'b1;
          end else begin
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            prog_len_d = prog_len_q + (ADDR_W+1)'(1);
            half_d     = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (valid_q && instr_ready) begin
          if (last || (opcode_of(instr_q) == OP_HALT)) begin
            valid_d = 1'b0;
            state_d = ST_FIN;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            instr_d = rd_data;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      half_q     <= 1'b0;
      hi_q       <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      half_q     <= half_d;
      hi_q       <= hi_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  instr_buffer #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_buffer (
    .clk     (clk),
    .we_i    (mem_we && ena && rst_n),
    .waddr_i (wr_ptr_q),
    .wdata_i ({hi_q, wr_byte}),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_FIN);
  assign prog_len    = prog_len_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - directed self-checking bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  wr_byte = '0;
  logic        wr_valid = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [4:0]  prog_len;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_sequencer #(.DEPTH(16), .ADDR_W(4), .INSTR_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .wr_byte     (wr_byte),
    .wr_valid    (wr_valid),
    .clear       (clear),
    .start       (start),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done),
    .prog_len    (prog_len),
    .overflow    (overflow)
  );

  // All helpers begin and end on a falling edge, away from the active edge.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_byte  = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] w);
    write_byte(w[15:8]);
    write_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (instr_out !== 16'h0) begin errors++; $display("FAIL reset_instr_out got %h want 0000", instr_out); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if ({busy, done, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, overflow}); end
    checks++; if (prog_len !== 5'd0) begin errors++; $display("FAIL reset_prog_len got %0d want 0", prog_len); end
  endtask

  task automatic test_basic();
    logic [15:0] exp [3];
    exp[0] = 16'h1205; exp[1] = 16'h1303; exp[2] = 16'h2010;
    do_reset();
    instr_ready = 1'b1;
    write_word(16'h1205); write_word(16'h1303); write_word(16'h2010);
    checks++; if (prog_len !== 5'd3) begin errors++; $display("FAIL basic_prog_len got %0d want 3", prog_len); end
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr_out !== exp[i] || busy !== 1'b1) begin errors++; $display("FAIL basic_word%0d got v=%b %h busy=%b want v=1 %h busy=1", i, instr_valid, instr_out, busy, exp[i]); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL basic_done got done=%b v=%b want done=1 v=0", done, instr_valid); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    pulse_start();
    checks++; if (instr_valid !== 1'b1 || instr_out !== 16'h1205) begin errors++; $display("FAIL stall_word0 got v=%b %h want v=1 1205", instr_valid, instr_out); end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_valid !== 1'b1 || instr_out !== 16'h1303) begin errors++; $display("FAIL stall_hold%0d got v=%b %h want v=1 1303", i, instr_valid, instr_out); end
      if (i < 3) @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr_out !== 16'h2010) begin errors++; $display("FAIL stall_word2 got v=%b %h want v=1 2010", instr_valid, instr_out); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL stall_done got done=%b v=%b want 1 0", done, instr_valid); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [15:0] w;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      w = {8'(8'h10 + i), 8'(i)};
      write_word(w);
    end
    checks++; if (prog_len !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full got len=%0d ovf=%b want 16 0", prog_len, overflow); end
    write_word(16'h2099);
    checks++; if (prog_len !== 5'd16 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got len=%0d ovf=%b want 16 1", prog_len, overflow); end
    instr_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      w = {8'(8'h10 + i), 8'(i)};
      checks++; if (instr_valid !== 1'b1 || instr_out !== w) begin errors++; $display("FAIL ovf_replay%0d got v=%b %h want v=1 %h", i, instr_valid, instr_out, w); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL ovf_done got done=%b v=%b want 1 0", done, instr_valid); end
    @(negedge clk);
    pulse_clear();
    checks++; if (prog_len !== 5'd0 || overflow !== 1'b0) begin errors++; $display("FAIL clear got len=%0d ovf=%b want 0 0", prog_len, overflow); end
  endtask

  task automatic test_halt();
    do_reset();
    instr_ready = 1'b1;
    write_word(16'h1205); write_word(16'hF000); write_word(16'h2010);
    pulse_start();
    checks++; if (instr_out !== 16'h1205 || instr_valid !== 1'b1) begin errors++; $display("FAIL halt_word0 got v=%b %h want v=1 1205", instr_valid, instr_out); end
    @(negedge clk);
    checks++; if (instr_out !== 16'hF000 || instr_valid !== 1'b1) begin errors++; $display("FAIL halt_word1 got v=%b %h want v=1 f000", instr_valid, instr_out); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_done got done=%b v=%b want 1 0", done, instr_valid); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL halt_no_more got v=%b busy=%b want 0 0", instr_valid, busy); end
  endtask

  task automatic test_empty_and_partial();
    do_reset();
    pulse_start();
    checks++; if (done !== 1'b1 || instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL empty_done got done=%b v=%b busy=%b want 1 0 0", done, instr_valid, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_pulse got done=%b want 0", done); end
    write_byte(8'hAB);
    pulse_start();
    checks++; if (prog_len !== 5'd0 || done !== 1'b1) begin errors++; $display("FAIL partial_drop got len=%0d done=%b want 0 1", prog_len, done); end
    @(negedge clk);
    write_word(16'h1205);
    checks++; if (prog_len !== 5'd1) begin errors++; $display("FAIL partial_realign_len got %0d want 1", prog_len); end
    pulse_start();
    checks++; if (instr_out !== 16'h1205 || instr_valid !== 1'b1) begin errors++; $display("FAIL partial_realign got v=%b %h want v=1 1205", instr_valid, instr_out); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    instr_ready = 1'b1;
    write_word(16'h1205); write_word(16'h1303); write_word(16'h2010);
    pulse_start();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({instr_out, instr_valid, busy, done, overflow} !== 20'h0 || prog_len !== 5'd0) begin errors++; $display("FAIL rst_run got %h v=%b b=%b d=%b o=%b len=%0d want all 0", instr_out, instr_valid, busy, done, overflow, prog_len); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_no_done got %b want 0", done); end
    write_word(16'h3456);
    checks++; if (prog_len !== 5'd1) begin errors++; $display("FAIL rst_load_state got len=%0d want 1", prog_len); end
  endtask

  task automatic test_ena_hold();
    do_reset();
    instr_ready = 1'b1;
    write_word(16'h1205); write_word(16'h1303); write_word(16'h2010);
    pulse_start();
    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (instr_out !== 16'h1303 || instr_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ena_hold%0d got v=%b %h busy=%b want v=1 1303 busy=1", i, instr_valid, instr_out, busy); end
    end
    ena = 1'b1;
    @(negedge clk);
    checks++; if (instr_out !== 16'h2010 || instr_valid !== 1'b1) begin errors++; $display("FAIL ena_resume got v=%b %h want v=1 2010", instr_valid, instr_out); end
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ena_done_hold got %b want 1", done); end
    ena = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b0 || prog_len !== 5'd3) begin errors++; $display("FAIL ena_done_release got done=%b len=%0d want 0 3", done, prog_len); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_halt();
    test_empty_and_partial();
    test_reset_mid_run();
    test_ena_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
